pc_gen_unit: RTL

//  Parametrised program-counter generator for the RV single-cycle core, successor to the PC control block.

---
 rtl/pc_gen_unit.sv | 102 ++++++++++
 1 files changed

// File: rtl/pc_gen_unit.sv
// pc_gen_unit: PC register with next-PC select, alignment check and optional return-address stack (PC_RAS_EN)
module pc_gen_unit #(
  parameter int XLEN = 32,
  parameter logic [XLEN-1:0] RESET_VEC = '0,
  parameter int IALIGN = 32,
  parameter int RAS_DEPTH = 4
) (
  input  logic            clock,
  input  logic            Reset,
  input  logic [2:0]      pc_sel,
  input  logic            br_taken,
  input  logic [XLEN-1:0] br_offset,
  input  logic [XLEN-1:0] jal_offset,
  input  logic [XLEN-1:0] jalr_base,
  input  logic [XLEN-1:0] jalr_offset,
  input  logic [XLEN-1:0] trap_vec,
  input  logic [XLEN-1:0] epc,
  input  logic            stall,
  input  logic            fetch_ready,
  input  logic            is_call,
  input  logic            is_ret,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_next,
  output logic            fetch_valid,
  output logic            misalign,
  output logic [XLEN-1:0] bad_addr,
  output logic [XLEN-1:0] ras_top,
  output logic            ras_valid
);
  logic [XLEN-1:0] seq_pc;
  logic            is_trap;
  logic            commit;
  logic            bad_tgt;
  logic            ok_commit;
  // next-PC selection and the committing-cycle alignment check
  always_comb begin
    seq_pc = pc + XLEN'(4);
    pc_next = pc_sel == 3'b001 ? (br_taken ? pc + br_offset : seq_pc) :
              pc_sel == 3'b010 ? pc + jal_offset :
              pc_sel == 3'b011 ? (jalr_base + jalr_offset) & ~XLEN'(1) :
              pc_sel == 3'b100 ? trap_vec :
              pc_sel == 3'b101 ? epc : seq_pc;
    is_trap = pc_sel == 3'b100;
    commit = fetch_valid & fetch_ready & ~stall & ~is_trap;
    bad_tgt = commit & (IALIGN == 16 ? pc_next[0] : |pc_next[1:0]);
    ok_commit = commit & ~bad_tgt;
  end
  // architectural PC, fetch-valid and misalign reporting
  always_ff @(posedge clock) begin
    if (!Reset) begin
      pc <= RESET_VEC;
      fetch_valid <= 1'b0;
      misalign <= 1'b0;
      bad_addr <= '0;
    end else begin
      fetch_valid <= 1'b1;
      misalign <= bad_tgt;
      if (bad_tgt) bad_addr <= pc_next;
      if (is_trap | ok_commit) pc <= pc_next;
    end
  end
`ifdef PC_RAS_EN
  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(RAS_DEPTH);
  logic [XLEN-1:0] ras [RAS_DEPTH];
  logic [PW-1:0]   ptr;
  logic [CW-1:0]   cnt;
  logic            push;
  logic            pop;
  logic [PW-1:0]   ptr_inc;
  // push/pop qualification; the pointer always indexes the current top entry
  always_comb begin
    push = ok_commit & is_call & (pc_sel == 3'b010 | pc_sel == 3'b011);
    pop = ok_commit & is_ret & pc_sel == 3'b011;
    ptr_inc = ptr + 1'b1;
    ras_valid = cnt != '0;
    ras_top = ras_valid ? ras[ptr] : '0;
  end
  // circular stack: a full push overwrites the oldest slot, an empty pop is ignored
  always_ff @(posedge clock) begin
    if (!Reset) begin
      ptr <= '0;
      cnt <= '0;
    end else if (push & pop) begin
      ras[ptr] <= seq_pc;
    end else if (push) begin
      ras[ptr_inc] <= seq_pc;
      ptr <= ptr_inc;
      cnt <= cnt == FULL ? cnt : cnt + 1'b1;
    end else if (pop & ras_valid) begin
      ptr <= ptr - 1'b1;
      cnt <= cnt - 1'b1;
    end
  end
`else
  logic unused_ras;
  assign unused_ras = ^{is_call, is_ret, ok_commit};
  assign ras_top = '0;
  assign ras_valid = 1'b0;
`endif
endmodule
